// File: rtl/time_entry_loader.sv
// Keypad entry buffer for the M:SS microwave timer: shifts in BCD digits, validates them on
// Start, and issues a single active-low parallel-load strobe to the timer counter stages.
module time_entry_loader #(
    parameter int MAX_DIGITS = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       key_cancel,
    input  logic       start_req,
    input  logic       timer_busy,
    output logic [3:0] min_digit,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       load_n,
    output logic [1:0] digit_count,
    output logic       entry_err,
    output logic       running
);

    typedef enum logic [1:0] {IDLE, ENTRY, LOAD, RUN} state_t;

    state_t state;
    logic   run_armed;
    logic   key_legal;
    logic   buf_full;

    assign key_legal = (key_digit <= 4'd9);
    assign buf_full  = (digit_count == 2'(MAX_DIGITS));
    assign running   = (state == LOAD) || (state == RUN);

    always_ff @(posedge clk) begin
        if (clear) begin
            state       <= IDLE;
            min_digit   <= '0;
            sec_tens    <= '0;
            sec_units   <= '0;
            digit_count <= '0;
            load_n      <= 1'b1;
            entry_err   <= 1'b0;
            run_armed   <= 1'b0;
        end else begin
            case (state)
                IDLE, ENTRY: begin
                    if (key_cancel) begin
                        min_digit   <= '0;
                        sec_tens    <= '0;
                        sec_units   <= '0;
                        digit_count <= '0;
                        entry_err   <= 1'b0;
                        state       <= IDLE;
                    end else if (key_valid) begin
                        // a key always takes precedence over a simultaneous Start
                        if (!key_legal || buf_full) begin
                            entry_err <= 1'b1;
                        end else begin
                            min_digit   <= sec_tens;
                            sec_tens    <= sec_units;
                            sec_units   <= key_digit;
                            digit_count <= digit_count + 2'd1;
                            state       <= ENTRY;
                        end
                    end else if (start_req) begin
                        if (state == IDLE || sec_tens > 4'd5) begin
                            entry_err <= 1'b1;
                        end else if (!timer_busy) begin
                            entry_err <= 1'b0;
                            state     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    // two edges in LOAD: the first drops load_n, the second releases it
                    if (load_n) begin
                        load_n <= 1'b0;
                    end else begin
                        load_n    <= 1'b1;
                        run_armed <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (!run_armed) begin
                        run_armed <= 1'b1;
                    end else if (!timer_busy) begin
                        min_digit   <= '0;
                        sec_tens    <= '0;
                        sec_units   <= '0;
                        digit_count <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/time_entry_loader.md
# time_entry_loader

Keypad-side front end of the microwave MS timer: collects BCD digits typed by the user, shifts them into a three-digit M:SS entry buffer, validates it, and drives the timer's parallel-load interface with a one-cycle active-low load strobe. It produces the data that the Counter_MOD6/MOD10 timer stages consume on their load port, and waits for the timer to finish before accepting a new entry.

## Interface
Parameters:
- MAX_DIGITS, 3, number of digits held in the entry buffer (M, S tens, S units); fixed at 3 for this design.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clear  input  1  synchronous reset, active-high; one clock, reset is synchronous and active-high.
- key_valid  input  1  one-cycle strobe: key_digit holds a new key.
- key_digit  input  4  BCD key code; values 10–15 are illegal.
- key_cancel  input  1  discard the entry buffer (ignored in RUN).
- start_req  input  1  one-cycle strobe: user pressed Start.
- timer_busy  input  1  high while the timer is counting down (not at zero).
- min_digit  output  4  entry buffer minutes digit (timer MOD10 load data).
- sec_tens  output  4  entry buffer seconds-tens digit (timer MOD6 load data).
- sec_units  output  4  entry buffer seconds-units digit (timer MOD10 load data).
- load_n  output  1  active-low load strobe to all timer stages, exactly one cycle.
- digit_count  output  2  digits entered so far, 0–3.
- entry_err  output  1  sticky error flag: illegal key, overflow key, or invalid start.
- running  output  1  high in LOAD and RUN states.

## Operation
- States: IDLE, ENTRY, LOAD, RUN.
- IDLE: buffer 0:00, digit_count 0. Legal key_valid -> shift in, go ENTRY. start_req with digit_count 0 -> entry_err=1, stay IDLE.
- Shift rule on a legal key (key_digit ≤ 9, digit_count < 3): min_digit <= sec_tens, sec_tens <= sec_units, sec_units <= key_digit, digit_count += 1.
- Illegal key (key_digit ≥ 10): no shift, entry_err=1, state unchanged.
- Fourth key (digit_count = 3): no shift, entry_err=1.
- ENTRY: key_cancel -> buffer 0:00, digit_count 0, entry_err 0, go IDLE. key_cancel and key_valid in the same cycle: cancel wins, key dropped.
- ENTRY start_req: if sec_tens ≤ 5 and timer_busy = 0 -> go LOAD; if sec_tens > 5 -> entry_err=1, stay ENTRY (user must cancel); if timer_busy = 1 -> stay ENTRY, no error, request dropped.
- start_req and key_valid in the same cycle in ENTRY: key processed, start dropped.
- LOAD: load_n = 0 for exactly this one cycle; buffer held stable; go RUN next cycle.
- RUN: all keys, cancel and start ignored; buffer held. When timer_busy samples 0 (after at least one cycle in RUN) -> buffer 0:00, digit_count 0, go IDLE.
- entry_err clears only on clear, key_cancel, or a successful transition into LOAD.

## Timing
- Reset values (clear=1 at a rising edge): state IDLE, min_digit/sec_tens/sec_units 0, digit_count 0, load_n 1, entry_err 0, running 0.
- clear has priority over every other input in the same cycle, including mid-LOAD (load_n returns to 1 at that edge).
- Key to buffer latency: 1 cycle (outputs registered).
- start_req accepted at edge N -> load_n low during cycle N+1 -> RUN from edge N+2; data valid on buffer outputs ≥1 cycle before and during load_n low.
- RUN ignores timer_busy during its first cycle (timer needs one edge to reflect the loaded value); exit to IDLE at the first later edge with timer_busy = 0.
- All outputs registered; no combinational input-to-output paths.
- Never more than one load_n pulse per accepted start.

## Test plan
- Reset: assert clear 2 cycles -> all digits 0, load_n 1, digit_count 0, entry_err 0, running 0.
- Entry 1,3,0 then start with timer_busy 0 -> buffer 1:30, digit_count 3, load_n low exactly one cycle two edges after start, running 1; drop timer_busy after 5 cycles -> IDLE, buffer 0:00.
- Illegal/overflow: key 12 -> entry_err 1, buffer unchanged; keys 4,5,6,7 -> 4:56 retained, 7 rejected, entry_err 1.
- Invalid seconds: keys 0,9,0 then start -> sec_tens 9, entry_err 1, no load_n pulse; key_cancel -> 0:00, entry_err 0, IDLE.
- Simultaneous events: key_valid 2 with key_cancel -> buffer 0:00, IDLE; key_valid 3 with start_req in ENTRY -> 3 shifted, no load.
- Mid-operation reset: clear during LOAD cycle -> load_n 1 at that edge, IDLE, 0:00; keys and start during RUN -> buffer and load_n unchanged.
